// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        VALID,
        FLUSH,
        HALTED
    } fetch_state_t;

    localparam int unsigned DEF_ADDR_W      = 8;
    localparam int unsigned DEF_DATA_W      = 8;
    localparam int unsigned DEF_NBYTES      = 3;
    localparam int unsigned DEF_RESET_PC    = 0;
    localparam logic [7:0]  DEF_HALT_OPCODE = 8'hFF;

    // Width of the byte-slot counter; a single-byte instruction still gets one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fetch_pc_counter.sv
// Program counter: loads a branch target or advances by one instruction length.
module fetch_pc_counter #(
    parameter int unsigned        ADDR_W   = 8,
    parameter int unsigned        NBYTES   = 3,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              advance,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(NBYTES);

    // Branch load wins over advance; the add wraps modulo 2^ADDR_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_val;
        end else if (advance) begin
            pc <= pc + STEP;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: requests NBYTES bytes one at a time from byte-wide
// memory, assembles them into inst_reg and hands the instruction to control.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W      = DEF_ADDR_W,
    parameter int unsigned       DATA_W      = DEF_DATA_W,
    parameter int unsigned       NBYTES      = DEF_NBYTES,
    parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEF_RESET_PC),
    parameter logic [DATA_W-1:0] HALT_OPCODE = DATA_W'(DEF_HALT_OPCODE)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_valid,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [NBYTES*DATA_W-1:0] inst_reg,
    output logic [ADDR_W-1:0]        pc,
    input  logic                     branch_en,
    input  logic [ADDR_W-1:0]        branch_addr,
    output logic                     halted
);

    localparam int unsigned      CNT_W     = cnt_width(NBYTES);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

    fetch_state_t      state;
    logic [CNT_W-1:0]  byte_cnt;
    logic [DATA_W-1:0] opcode;
    logic              pc_advance;
    logic              byte_wr;

    assign opcode     = inst_reg[NBYTES*DATA_W-1 -: DATA_W];
    assign mem_req    = (state == REQ) && !stall;
    assign inst_valid = (state == VALID);
    assign halted     = (state == HALTED);
    assign mem_addr   = pc + ADDR_W'(byte_cnt);
    assign pc_advance = (state == VALID) && inst_ready;
    assign byte_wr    = (state == WAIT) && mem_valid && !branch_en;

    fetch_pc_counter #(
        .ADDR_W   (ADDR_W),
        .NBYTES   (NBYTES),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (branch_en),
        .load_val (branch_addr),
        .advance  (pc_advance),
        .pc       (pc)
    );

    // Fetch sequencing; a branch overrides whatever the current state would do.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            byte_cnt <= '0;
        end else if (branch_en) begin
            byte_cnt <= '0;
            unique case (state)
                // A request still in flight must drain before fetching anew.
                // In REQ the request goes out this very cycle unless stalled.
                // A branch in FLUSH coinciding with the awaited mem_valid has
                // nothing left to drain, so it moves on instead of waiting forever.
                REQ:     state <= stall ? REQ : FLUSH;
                WAIT:    state <= mem_valid ? REQ : FLUSH;
                FLUSH:   state <= mem_valid ? REQ : FLUSH;
                default: state <= REQ;
            endcase
        end else begin
            unique case (state)
                IDLE:    state <= REQ;
                REQ:     if (!stall) state <= WAIT;
                WAIT: begin
                    if (mem_valid) begin
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= '0;
                            state    <= VALID;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                            state    <= REQ;
                        end
                    end
                end
                VALID:   if (inst_ready) state <= (opcode == HALT_OPCODE) ? HALTED : REQ;
                FLUSH:   if (mem_valid) state <= REQ;
                HALTED:  state <= HALTED;
                default: state <= IDLE;
            endcase
        end
    end

    // Drop each returned byte into its slot; byte 0 lands in the MSBs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_reg <= '0;
        end else if (byte_wr) begin
            inst_reg[(NBYTES - 1 - int'(byte_cnt))*DATA_W +: DATA_W] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: latency-configurable memory plus a
// transaction-level model of which instruction bytes should be fetched.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_valid = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [23:0] inst_reg;
    logic [7:0]  pc;
    logic        branch_en = 1'b0;
    logic [7:0]  branch_addr = 8'h00;
    logic        halted;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_valid   (mem_valid),
        .mem_rdata   (mem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_reg    (inst_reg),
        .pc          (pc),
        .branch_en   (branch_en),
        .branch_addr (branch_addr),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    int n_cmp = 0;
    int n_bad = 0;

    // reference model: address of the instruction being fetched and
    // how many of its bytes have been requested so far
    logic [7:0] exp_pc = 8'h00;
    int         exp_byte = 0;
    bit         exp_halted = 1'b0;
    // memory model: single outstanding request
    bit         pend = 1'b0;
    logic [7:0] pend_addr = 8'h00;
    int         pend_cnt = 0;
    int         lat_min = 1;
    int         lat_max = 1;
    int         req_count = 0;
    int         vld_count = 0;
    int         handoffs = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] exp_inst(input logic [7:0] a);
        return {mem[a], mem[8'(a + 8'd1)], mem[8'(a + 8'd2)]};
    endfunction

    // One clock: drive inputs at the falling edge, check what the rising edge will see.
    task automatic step(input bit rdy, input bit stl, input bit want_br, input logic [7:0] baddr);
        bit mvld;
        bit br;
        bit req;
        bit hand;
        @(negedge clk);
        br   = want_br && (inst_valid || halted || pend);
        mvld = 1'b0;
        if (pend && pend_cnt == 0) begin
            mvld      = 1'b1;
            mem_rdata = mem[pend_addr];
        end
        mem_valid   = mvld;
        stall       = stl;
        inst_ready  = rdy;
        branch_en   = br;
        branch_addr = baddr;
        #1;
        check("halted", halted, exp_halted);
        req = mem_req;
        if (stl)        check("stall_blocks_req", req, 0);
        if (exp_halted) check("halted_no_req", req, 0);
        if (pend) begin
            if (mvld) pend = 1'b0;
            else      pend_cnt--;
        end
        if (mvld) vld_count++;
        if (req) begin
            check("one_outstanding", pend, 0);
            check("mem_addr", mem_addr, 8'(exp_pc + 8'(exp_byte)));
            pend      = 1'b1;
            pend_addr = mem_addr;
            pend_cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
            exp_byte++;
            req_count++;
        end
        hand = inst_valid && rdy;
        if (hand) begin
            check("handoff_pc", pc, exp_pc);
            check("handoff_inst", inst_reg, exp_inst(exp_pc));
            handoffs++;
        end
        if (br) begin
            exp_pc     = baddr;
            exp_byte   = 0;
            exp_halted = 1'b0;
        end else if (hand) begin
            if (mem[exp_pc] == 8'hFF) exp_halted = 1'b1;
            exp_pc   = 8'(exp_pc + 8'd3);
            exp_byte = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_valid(input int maxc);
        for (int i = 0; i < maxc && !inst_valid; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
        check("inst_valid_timeout", inst_valid, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"}, pc, 8'h00);
        check({tag, "_inst_valid"}, inst_valid, 0);
        check({tag, "_mem_req"}, mem_req, 0);
        check({tag, "_halted"}, halted, 0);
        check({tag, "_inst_reg"}, inst_reg, 24'h0);
        check({tag, "_mem_addr"}, mem_addr, 8'h00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int v0;
        int h0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom_range(8'hFE, 0));
        end
        mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56;
        mem[8'h40] = 8'h41; mem[8'hFE] = 8'h11;
        mem[8'h10] = 8'h22;

        // reset state
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // first instruction, latency 1
        run_until_valid(20);
        check("t1_inst", inst_reg, 24'h123456);
        check("t1_pc", pc, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("t1_pc_adv", pc, 8'h03);
        check("t1_next_addr", mem_addr, 8'h03);

        // latency 3 with 4 stalled cycles in REQ
        lat_min = 3; lat_max = 3;
        repeat (4) step(1'b0, 1'b1, 1'b0, 8'h00);
        r0 = req_count; v0 = vld_count;
        run_until_valid(60);
        check("t2_reqs", req_count - r0, 3);
        check("t2_valids", vld_count - v0, 3);
        step(1'b1, 1'b0, 1'b0, 8'h00);

        // branch while waiting for data
        for (int i = 0; i < 20 && !pend; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h40);
        check("t3_pc", pc, 8'h40);
        run_until_valid(80);
        check("t3_inst", inst_reg, exp_inst(8'h40));
        check("t3_pc_valid", pc, 8'h40);
        step(1'b1, 1'b0, 1'b0, 8'h00);

        // address wrap at the top of memory
        lat_min = 1; lat_max = 3;
        run_until_valid(60);
        step(1'b1, 1'b0, 1'b1, 8'hFE);
        run_until_valid(60);
        check("t4_pc", pc, 8'hFE);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("t4_wrap_pc", pc, 8'h01);

        // halt opcode
        mem[0] = 8'hFF;
        run_until_valid(60);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        run_until_valid(60);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        repeat (10) step(1'($urandom_range(1, 0)), 1'b0, 1'b0, 8'h00);
        check("t5_halted", halted, 1);
        step(1'b0, 1'b0, 1'b1, 8'h10);
        check("t5_unhalted", halted, 0);
        run_until_valid(60);
        check("t5_pc", pc, 8'h10);
        step(1'b1, 1'b0, 1'b0, 8'h00);

        // randomized traffic
        lat_min = 1; lat_max = 4;
        h0 = handoffs;
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(1, 0)), ($urandom_range(3, 0) == 0),
                 ($urandom_range(9, 0) == 0), 8'($urandom_range(255, 0)));
        end
        check("rand_progress", (handoffs - h0) > 20, 1);

        // asynchronous reset in the middle of a read
        lat_min = 3; lat_max = 3;
        step(1'b0, 1'b0, 1'b1, 8'h20);
        for (int i = 0; i < 40 && !pend; i++) step(1'b1, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        mem_valid = 1'b0; branch_en = 1'b0; inst_ready = 1'b0; stall = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        pend = 1'b0; exp_pc = 8'h00; exp_byte = 0; exp_halted = 1'b0;
        mem[0] = 8'h21; mem[1] = 8'h43; mem[2] = 8'h65;
        @(posedge clk);
        #1;
        check("async_hold_pc", pc, 8'h00);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_valid = 1'b1;
        mem_rdata = 8'hEE;
        @(posedge clk);
        #1;
        check("async_first_addr", mem_addr, 8'h00);
        run_until_valid(60);
        check("t6_inst", inst_reg, 24'h214365);
        check("t6_pc", pc, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
